// File: rtl/trigger_accum_n.sv
// Per-bunch-crossing trigger accumulator: gathers deduplicated channel hits over
// one 8-phase BC framed by mt_cou, then registers tt/ta/tcm_req, the in-window
// multiplicity and the amplitude sum at the BC boundary (mt_cou == 7).
module trigger_accum_n #(
   parameter int unsigned NCH = 12,
   parameter int unsigned TW  = 12,
   parameter int unsigned AW  = 12,
   parameter int unsigned CW  = $clog2(NCH + 1),
   parameter int unsigned SW  = AW + CW
) (
   input  logic               clk320,
   input  logic               rst,
   input  logic [2:0]         mt_cou,
   input  logic [NCH-1:0]     CH_trigt,
   input  logic [NCH*TW-1:0]  CH_time,
   input  logic [NCH*AW-1:0]  CH_ampl,
   input  logic [NCH-1:0]     ch_mask,
   input  logic [TW-1:0]      t_lo,
   input  logic [TW-1:0]      t_hi,
   input  logic [CW-1:0]      mult_thr,
   input  logic [SW-1:0]      amp_thr,
   output logic               tt,
   output logic               ta,
   output logic               tcm_req,
   output logic [CW-1:0]      mult,
   output logic [SW-1:0]      ampl_sum
);

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [NCH-1:0]  seen_q, seen_d;
   logic [CW-1:0]   acc_win_q, acc_win_d;
   logic [CW-1:0]   acc_hit_q, acc_hit_d;
   logic [SW-1:0]   acc_amp_q, acc_amp_d;
   logic            tt_q, tt_d;
   logic            ta_q, ta_d;
   logic            tcm_q, tcm_d;
   logic [CW-1:0]   mult_q, mult_d;
   logic [SW-1:0]   sum_q, sum_d;

   logic [NCH-1:0]  accept_c;
   logic [CW-1:0]   win_next_c;
   logic [CW-1:0]   hit_next_c;
   logic [SW-1:0]   amp_next_c;
   logic            boundary_c;

   assign boundary_c = (mt_cou == 3'd7);

   // Accumulator values including this cycle's first-strobe, unmasked hits
   always_comb begin
      accept_c   = '0;
      win_next_c = acc_win_q;
      hit_next_c = acc_hit_q;
      amp_next_c = acc_amp_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         accept_c[i] = CH_trigt[i] & ch_mask[i] & ~seen_q[i];
         if (accept_c[i]) begin
            hit_next_c = hit_next_c + CW'(1);
            amp_next_c = amp_next_c + SW'(CH_ampl[i*AW +: AW]);
            if (($signed(CH_time[i*TW +: TW]) >= $signed(t_lo)) &&
                ($signed(CH_time[i*TW +: TW]) <= $signed(t_hi))) begin
               win_next_c = win_next_c + CW'(1);
            end
         end
      end
   end

   // Next state: SYNC discards the partial first BC, RUN publishes at each boundary
   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q | accept_c;
      acc_win_d = win_next_c;
      acc_hit_d = hit_next_c;
      acc_amp_d = amp_next_c;
      tt_d      = tt_q;
      ta_d      = ta_q;
      tcm_d     = tcm_q;
      mult_d    = mult_q;
      sum_d     = sum_q;
      case (state_q)
         ST_SYNC: begin
            seen_d    = '0;
            acc_win_d = '0;
            acc_hit_d = '0;
            acc_amp_d = '0;
            if (boundary_c) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (boundary_c) begin
               mult_d    = win_next_c;
               sum_d     = amp_next_c;
               tt_d      = (win_next_c >= mult_thr) && (win_next_c != '0);
               ta_d      = (amp_next_c >= amp_thr);
               tcm_d     = (hit_next_c != '0);
               seen_d    = '0;
               acc_win_d = '0;
               acc_hit_d = '0;
               acc_amp_d = '0;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   // State, accumulators and published results
   always_ff @(posedge clk320 or posedge rst) begin
      if (rst) begin
         state_q   <= ST_SYNC;
         seen_q    <= '0;
         acc_win_q <= '0;
         acc_hit_q <= '0;
         acc_amp_q <= '0;
         tt_q      <= 1'b0;
         ta_q      <= 1'b0;
         tcm_q     <= 1'b0;
         mult_q    <= '0;
         sum_q     <= '0;
      end else begin
         state_q   <= state_d;
         seen_q    <= seen_d;
         acc_win_q <= acc_win_d;
         acc_hit_q <= acc_hit_d;
         acc_amp_q <= acc_amp_d;
         tt_q      <= tt_d;
         ta_q      <= ta_d;
         tcm_q     <= tcm_d;
         mult_q    <= mult_d;
         sum_q     <= sum_d;
      end
   end

   assign tt       = tt_q;
   assign ta       = ta_q;
   assign tcm_req  = tcm_q;
   assign mult     = mult_q;
   assign ampl_sum = sum_q;

endmodule
